pipe_stage_sequencer: RTL
=========================

# pipe_stage_sequencer

Sequential pipeline backbone of the five-stage RV32I core: owns the fetch PC and the F/D, D/X, X/M and M/W instruction registers. It acts on the `stall` and `pc_sel` decisions of the hazard/forwarding controller: it holds fetch/decode on load-use, injects bubbles, and squashes wrong-path instructions on taken branches and jumps. It sources the per-stage instruction words that the controller decodes, closing the control loop.

## Interface
- `RESET_PC`, default 32'h01000000: fetch address after reset.
- `NOP_INSN`, default 32'h00000013: bubble encoding (`addi x0,x0,0`).
- `clock`  in  1  core clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `f_insn`  in  32  instruction word read from imem at `f_pc`; combinational, same cycle.
- `f_valid`  in  1  `f_insn` is usable this cycle.
- `stall`  in  1  load-use stall request, referring to the instruction currently in X.
- `pc_sel`  in  1  redirect request from the branch/jump currently in X.
- `pc_target`  in  32  redirect address (ALU result).
- `f_pc`  out  32  current fetch address.
- `d_insn`/`x_insn`/`m_insn`/`w_insn`  out  32 each  stage instruction words.
- `d_pc`/`x_pc`/`m_pc`/`w_pc`  out  32 each  stage PCs.
- `d_valid`/`x_valid`/`m_valid`/`w_valid`  out  1 each  stage holds a real instruction, not a bubble.

## Operation
- Reset (async): `f_pc`=`RESET_PC`. All stage insns = `NOP_INSN`. All stage PCs = 0. All valids = 0. Counters = 0.
- Effective requests: `redir = pc_sel & x_valid`; `hold = stall & x_valid & ~redir`. Requests arriving with X holding a bubble are ignored.
- Normal advance (no `redir`, no `hold`):
  - F→D→X→M→W all shift.
  - `f_pc += 4`, wrapping modulo 2^32.
  - D is loaded with `{f_insn, f_pc, 1}`.
- `hold`:
  - `f_pc` and the D register keep their values.
  - X loads a bubble (`NOP_INSN`, PC 0, valid 0).
  - M←X and W←M continue to shift.
- `redir`:
  - `f_pc` ← `{pc_target[31:2], 2'b00}`.
  - D and X load bubbles.
  - M←X, so the branch/jump itself retires.
  - W←M.
- `f_valid`=0 with no `hold` or `redir`:
  - `f_pc` holds.
  - D loads a bubble.
  - X/M/W advance.
- Priority when requests coincide: `redir` > `hold` > `f_valid`=0.
  - `redir` always wins.
  - During `hold`, `f_valid` is ignored because D is frozen.
- W is terminal: the M/W contents are dropped on the next shift. Each W occupancy with `w_valid`=1 counts as one retire.
- Reset asserted mid-operation returns every register to its reset value immediately, independent of `clock`. In-flight instructions are lost.

## Timing
- An instruction fetched in cycle n occupies D at n+1, X at n+2, M at n+3, W at n+4. Latency is 4 cycles.
- `stall` sampled high in cycle n:
  - same `d_insn` at n+1;
  - bubble in X at n+1;
  - the X instruction moves to M at n+1.
- `pc_sel` sampled high in cycle n:
  - `f_pc`=target at n+1;
  - target instruction in D at n+2.
  - Taken-branch penalty is 2 bubbles.
- Back-to-back `stall` cycles each freeze D and insert one bubble.
- No combinational path from `stall`/`pc_sel` to any output. All outputs are registered.

## Configuration
- `PIPE_PERF_CNT_EN` defined:
  - adds outputs `stall_cnt`, `flush_cnt`, `retire_cnt` (out, 32 each);
  - the counters increment on cycles with `hold`, with `redir`, and with `w_valid`, respectively;
  - all three wrap at 2^32 and reset to 0.
- Macro undefined: the ports and counter logic are absent. Pipeline behaviour is identical in both cases.

## Structure
- Shared package `pipe_pkg`:
  - `NOP_INSN`;
  - stage record typedef `{insn[31:0], pc[31:0], valid}`;
  - bubble constant;
  - field-slice functions (`opcode`, `rd`, `rs1`, `rs2`, `funct3`, `funct7`) used by decode and the hazard controller.
- One sub-module, `pipe_stage_reg`:
  - a single stage record register with async reset to bubble, `load` and `bubble` controls;
  - instantiated four times (D, X, M, W).

## Test plan
- Reset release, `f_valid`=1, `f_insn`=32'h00500093 at `RESET_PC` → `w_insn`=32'h00500093, `w_pc`=32'h01000000, `w_valid`=1 exactly 4 cycles later; `f_pc`=32'h01000010 at that point.
- `lw x5` in X, `stall`=1 for one cycle → `d_insn` unchanged next cycle, `x_valid`=0, `m_insn`=the `lw`, `f_pc` unchanged; `stall_cnt`=1 when `PIPE_PERF_CNT_EN` is defined.
- `beq` at 32'h01000008 in X, `pc_sel`=1, `pc_target`=32'h01000040 → next cycle `f_pc`=32'h01000040 and `d_valid`=`x_valid`=0; target reaches D 2 cycles after `pc_sel`.
- `stall`=1 and `pc_sel`=1 together with a valid X → redirect taken, D and X squashed, `f_pc`=target; `stall` has no effect.
- `pc_sel`=1 while `x_valid`=0 → ignored, normal advance with `f_pc`+4; `pc_target`=32'h01000043 on a valid redirect → `f_pc`=32'h01000040.
- `reset` pulsed asynchronously mid-stream → all valids 0 and `f_pc`=32'h01000000 before the next clock edge.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline package: bubble encoding, stage record type and RV32I
// field-slice helpers used by decode and the hazard controller.
package pipe_pkg;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [31:0] RESET_PC = 32'h0100_0000;

  // One pipeline stage record: instruction word, its PC, and a valid flag
  // that distinguishes real instructions from injected bubbles.
  typedef struct packed {
    logic [31:0] insn;
    logic [31:0] pc;
    logic        valid;
  } stage_t;

  localparam stage_t BUBBLE = '{insn: NOP_INSN, pc: 32'h0000_0000, valid: 1'b0};

  // Bubble built around a caller-chosen NOP encoding.
  function automatic stage_t make_bubble(input logic [31:0] nop);
    stage_t s;
    s.insn  = nop;
    s.pc    = 32'h0000_0000;
    s.valid = 1'b0;
    return s;
  endfunction

  function automatic logic [6:0] opcode(input logic [31:0] insn);
    return insn[6:0];
  endfunction

  function automatic logic [4:0] rd(input logic [31:0] insn);
    return insn[11:7];
  endfunction

  function automatic logic [2:0] funct3(input logic [31:0] insn);
    return insn[14:12];
  endfunction

  function automatic logic [4:0] rs1(input logic [31:0] insn);
    return insn[19:15];
  endfunction

  function automatic logic [4:0] rs2(input logic [31:0] insn);
    return insn[24:20];
  endfunction

  function automatic logic [6:0] funct7(input logic [31:0] insn);
    return insn[31:25];
  endfunction

endpackage

// File: rtl/pipe_stage_sequencer_if.sv
// Bus between the pipeline backbone and its surroundings (imem fetch port,
// hazard/forwarding controller, decode). The master side is the controller
// and fetch source; the slave side is the sequencer itself.
// Optional macro PIPE_PERF_CNT_EN adds the performance counter signals.
interface pipe_stage_sequencer_if;

  logic [31:0] f_insn;
  logic        f_valid;
  logic        stall;
  logic        pc_sel;
  logic [31:0] pc_target;

  logic [31:0] f_pc;
  logic [31:0] d_insn;
  logic [31:0] x_insn;
  logic [31:0] m_insn;
  logic [31:0] w_insn;
  logic [31:0] d_pc;
  logic [31:0] x_pc;
  logic [31:0] m_pc;
  logic [31:0] w_pc;
  logic        d_valid;
  logic        x_valid;
  logic        m_valid;
  logic        w_valid;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
  logic [31:0] retire_cnt;

  modport master (
    output f_insn, f_valid, stall, pc_sel, pc_target,
    input  f_pc, d_insn, x_insn, m_insn, w_insn,
    input  d_pc, x_pc, m_pc, w_pc,
    input  d_valid, x_valid, m_valid, w_valid,
    input  stall_cnt, flush_cnt, retire_cnt
  );

  modport slave (
    input  f_insn, f_valid, stall, pc_sel, pc_target,
    output f_pc, d_insn, x_insn, m_insn, w_insn,
    output d_pc, x_pc, m_pc, w_pc,
    output d_valid, x_valid, m_valid, w_valid,
    output stall_cnt, flush_cnt, retire_cnt
  );
`else
  modport master (
    output f_insn, f_valid, stall, pc_sel, pc_target,
    input  f_pc, d_insn, x_insn, m_insn, w_insn,
    input  d_pc, x_pc, m_pc, w_pc,
    input  d_valid, x_valid, m_valid, w_valid
  );

  modport slave (
    input  f_insn, f_valid, stall, pc_sel, pc_target,
    output f_pc, d_insn, x_insn, m_insn, w_insn,
    output d_pc, x_pc, m_pc, w_pc,
    output d_valid, x_valid, m_valid, w_valid
  );
`endif

endinterface

// File: rtl/pipe_stage_reg.sv
// Single pipeline stage register. Resets to a bubble; 'bubble' overrides
// 'load', and with neither asserted the stage holds its contents.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter logic [31:0] BUBBLE_INSN = 32'h0000_0013
) (
  input  logic   clock,
  input  logic   reset,
  input  logic   load,
  input  logic   bubble,
  input  stage_t d,
  output stage_t q
);

  stage_t stage_r;

  // Stage state: bubble injection wins over a normal load, otherwise hold.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stage_r <= make_bubble(BUBBLE_INSN);
    end else if (bubble) begin
      stage_r <= make_bubble(BUBBLE_INSN);
    end else if (load) begin
      stage_r <= d;
    end else begin
      stage_r <= stage_r;
    end
  end

  assign q = stage_r;

endmodule

// File: rtl/pipe_stage_sequencer.sv
// Five-stage RV32I pipeline backbone: fetch PC plus the D, X, M and W stage
// registers. Applies the controller's stall/redirect decisions, which only
// take effect when X holds a real instruction. All outputs come straight
// from registers, so stall/pc_sel never reach an output combinationally.
// Optional macro PIPE_PERF_CNT_EN adds stall/flush/retire counters.
module pipe_stage_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0100_0000,
  parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
  input logic                  clock,
  input logic                  reset,
  pipe_stage_sequencer_if.slave bus
);

  import pipe_pkg::*;

  logic [31:0] f_pc_r;
  logic [31:0] f_pc_nxt_s;
  logic        redir_s;
  logic        hold_s;
  logic        d_bubble_s;
  logic        d_load_s;
  logic        x_bubble_s;
  stage_t      f_rec_s;
  stage_t      d_q_s;
  stage_t      x_q_s;
  stage_t      m_q_s;
  stage_t      w_q_s;

  // Effective requests, stage controls and next fetch PC (redir > hold > f_valid).
  always_comb begin
    redir_s    = bus.pc_sel & x_q_s.valid;
    hold_s     = bus.stall & x_q_s.valid & ~redir_s;
    d_bubble_s = 1'b0;
    d_load_s   = 1'b0;
    x_bubble_s = 1'b0;
    f_pc_nxt_s = f_pc_r;
    f_rec_s.insn  = bus.f_insn;
    f_rec_s.pc    = f_pc_r;
    f_rec_s.valid = 1'b1;
    if (redir_s) begin
      // Squash the two wrong-path slots; the branch itself moves on to M.
      d_bubble_s = 1'b1;
      x_bubble_s = 1'b1;
      f_pc_nxt_s = bus.pc_target & 32'hFFFF_FFFC;
    end else if (hold_s) begin
      // Freeze fetch and D; X takes a bubble while X moves to M.
      d_load_s   = 1'b0;
      x_bubble_s = 1'b1;
      f_pc_nxt_s = f_pc_r;
    end else if (!bus.f_valid) begin
      // Fetch not ready: D gets a bubble, the rest keeps draining.
      d_bubble_s = 1'b1;
      f_pc_nxt_s = f_pc_r;
    end else begin
      d_load_s   = 1'b1;
      f_pc_nxt_s = f_pc_r + 32'd4;
    end
  end

  // Fetch program counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      f_pc_r <= RESET_PC;
    end else begin
      f_pc_r <= f_pc_nxt_s;
    end
  end

  pipe_stage_reg #(.BUBBLE_INSN(NOP_INSN)) u_d_stage (
    .clock (clock),
    .reset (reset),
    .load  (d_load_s),
    .bubble(d_bubble_s),
    .d     (f_rec_s),
    .q     (d_q_s)
  );

  pipe_stage_reg #(.BUBBLE_INSN(NOP_INSN)) u_x_stage (
    .clock (clock),
    .reset (reset),
    .load  (1'b1),
    .bubble(x_bubble_s),
    .d     (d_q_s),
    .q     (x_q_s)
  );

  pipe_stage_reg #(.BUBBLE_INSN(NOP_INSN)) u_m_stage (
    .clock (clock),
    .reset (reset),
    .load  (1'b1),
    .bubble(1'b0),
    .d     (x_q_s),
    .q     (m_q_s)
  );

  pipe_stage_reg #(.BUBBLE_INSN(NOP_INSN)) u_w_stage (
    .clock (clock),
    .reset (reset),
    .load  (1'b1),
    .bubble(1'b0),
    .d     (m_q_s),
    .q     (w_q_s)
  );

  assign bus.f_pc    = f_pc_r;
  assign bus.d_insn  = d_q_s.insn;
  assign bus.d_pc    = d_q_s.pc;
  assign bus.d_valid = d_q_s.valid;
  assign bus.x_insn  = x_q_s.insn;
  assign bus.x_pc    = x_q_s.pc;
  assign bus.x_valid = x_q_s.valid;
  assign bus.m_insn  = m_q_s.insn;
  assign bus.m_pc    = m_q_s.pc;
  assign bus.m_valid = m_q_s.valid;
  assign bus.w_insn  = w_q_s.insn;
  assign bus.w_pc    = w_q_s.pc;
  assign bus.w_valid = w_q_s.valid;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt_r;
  logic [31:0] flush_cnt_r;
  logic [31:0] retire_cnt_r;

  // Performance counters: effective holds, effective redirects, retires in W.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cnt_r  <= 32'd0;
      flush_cnt_r  <= 32'd0;
      retire_cnt_r <= 32'd0;
    end else begin
      stall_cnt_r  <= hold_s      ? stall_cnt_r + 32'd1  : stall_cnt_r;
      flush_cnt_r  <= redir_s     ? flush_cnt_r + 32'd1  : flush_cnt_r;
      retire_cnt_r <= w_q_s.valid ? retire_cnt_r + 32'd1 : retire_cnt_r;
    end
  end

  assign bus.stall_cnt  = stall_cnt_r;
  assign bus.flush_cnt  = flush_cnt_r;
  assign bus.retire_cnt = retire_cnt_r;
`endif

endmodule
